// File: rtl/sa_pkg.sv
// Shared types and arithmetic helpers for the systolic matrix-multiply engine.
// Provides the controller state encoding and a width-generic saturating add.
package sa_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        FLUSH,
        DRAIN
    } sa_state_t;

    // Adds a sign-extended product onto an accumulator held in 64 bits.
    // sat=1 clamps to the signed range of 'bits'; sat=0 wraps to 'bits'.
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] acc,
        input logic signed [63:0] prod,
        input int                 bits,
        input logic               sat
    );
        logic signed [63:0] sum;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sum = acc + prod;
        hi  = (64'sd1 <<< (bits - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (bits - 1));
        if (sat) begin
            if (sum > hi) return hi;
            if (sum < lo) return lo;
            return sum;
        end
        return (sum <<< (64 - bits)) >>> (64 - bits);
    endfunction

endpackage

// File: rtl/sa_pe.sv
// One output-stationary processing element: passes A right and B down and
// multiply-accumulates on every advance.
// Ports: clk, rst, adv (advance), clr (zero accumulator), a_in/b_in operands,
//        a_out/b_out registered pass-through, acc accumulator value.
module sa_pe
    import sa_pkg::*;
#(
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16,
    parameter int SAT     = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      adv,
    input  logic                      clr,
    input  logic signed [BITS_AB-1:0] a_in,
    input  logic signed [BITS_AB-1:0] b_in,
    output logic signed [BITS_AB-1:0] a_out,
    output logic signed [BITS_AB-1:0] b_out,
    output logic        [BITS_C-1:0]  acc
);

    localparam int PW = 2 * BITS_AB;

    logic signed [BITS_AB-1:0] a_q, a_d;
    logic signed [BITS_AB-1:0] b_q, b_d;
    logic signed [BITS_C-1:0]  acc_q, acc_d;
    logic signed [PW-1:0]      prod;

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        prod  = PW'(a_in) * PW'(b_in);
        if (clr) begin
            acc_d = '0;
        end else if (adv) begin
            a_d   = a_in;
            b_d   = b_in;
            acc_d = BITS_C'(sat_add(64'(acc_q), 64'(prod),
                                    BITS_C, SAT != 0));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end

    assign a_out = a_q;
    assign b_out = b_q;
    assign acc   = acc_q;

endmodule

// File: rtl/systolic_array_stream.sv
// Output-stationary ROWSxCOLS systolic engine computing C = A*B over a streamed
// inner dimension, with input skewing and a feed/flush/drain controller.
// Ports: clk, rst; start/acc_clr tile control; in_valid/in_ready/in_last with
//        A (column k) and B (row k) operands; out_valid/out_ready/out_row/Cout
//        result rows; busy (not idle) and done (pulse after last row).
module systolic_array_stream
    import sa_pkg::*;
#(
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16,
    parameter int ROWS    = 8,
    parameter int COLS    = 8,
    parameter int SAT     = 1,
    localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           acc_clr,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_last,
    input  logic [ROWS-1:0][BITS_AB-1:0]   A,
    input  logic [COLS-1:0][BITS_AB-1:0]   B,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [RW-1:0]                  out_row,
    output logic [COLS-1:0][BITS_C-1:0]    Cout,
    output logic                           busy,
    output logic                           done
);

    localparam int FW = $clog2(ROWS + COLS);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(ROWS + COLS - 2);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

    sa_state_t     state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          done_q, done_d;

    logic adv;
    logic clr;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        fcnt_d  = fcnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FEED;
                    row_d   = '0;
                end
            end
            FEED: begin
                if (in_valid && in_last) begin
                    state_d = FLUSH;
                    fcnt_d  = '0;
                end
            end
            FLUSH: begin
                if (fcnt_q == FLUSH_LAST) state_d = DRAIN;
                else fcnt_d = fcnt_q + FW'(1);
            end
            DRAIN: begin
                if (out_ready) begin
                    if (row_q == ROW_LAST) begin
                        row_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            fcnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            fcnt_q  <= fcnt_d;
            done_q  <= done_d;
        end
    end

    // Stalled FEED cycles do not advance, so nothing shifts and no bubble
    // enters the array; FLUSH pushes zeros to carry the last beat through.
    assign adv = (state_q == FEED && in_valid) || (state_q == FLUSH);
    assign clr = (state_q == IDLE) && start && acc_clr;

    assign in_ready  = (state_q == FEED);
    assign out_valid = (state_q == DRAIN);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign out_row   = row_q;

    logic [ROWS-1:0][BITS_AB-1:0] a_inj, a_edge;
    logic [COLS-1:0][BITS_AB-1:0] b_inj, b_edge;

    assign a_inj = (state_q == FEED) ? A : '0;
    assign b_inj = (state_q == FEED) ? B : '0;

    // Lane i of A (and lane j of B) is delayed i (j) advances so operand k
    // meets its partner at PE(i,j) on advance k+i+j.
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_askew
        if (gi == 0) begin : g_direct
            assign a_edge[gi] = a_inj[gi];
        end else begin : g_sr
            logic [gi-1:0][BITS_AB-1:0] sr_q, sr_d;
            always_comb begin
                sr_d = sr_q;
                if (adv) begin
                    sr_d[0] = a_inj[gi];
                    for (int s = 1; s < gi; s++) sr_d[s] = sr_q[s-1];
                end
            end
            always_ff @(posedge clk or posedge rst) begin
                if (rst) sr_q <= '0;
                else     sr_q <= sr_d;
            end
            assign a_edge[gi] = sr_q[gi-1];
        end
    end

    for (genvar gj = 0; gj < COLS; gj++) begin : g_bskew
        if (gj == 0) begin : g_direct
            assign b_edge[gj] = b_inj[gj];
        end else begin : g_sr
            logic [gj-1:0][BITS_AB-1:0] sr_q, sr_d;
            always_comb begin
                sr_d = sr_q;
                if (adv) begin
                    sr_d[0] = b_inj[gj];
                    for (int s = 1; s < gj; s++) sr_d[s] = sr_q[s-1];
                end
            end
            always_ff @(posedge clk or posedge rst) begin
                if (rst) sr_q <= '0;
                else     sr_q <= sr_d;
            end
            assign b_edge[gj] = sr_q[gj-1];
        end
    end

    logic [BITS_AB-1:0] a_h [ROWS][COLS+1];
    logic [BITS_AB-1:0] b_v [ROWS+1][COLS];
    logic [COLS-1:0][BITS_C-1:0] acc_row [ROWS];
    logic [ROWS-1:0][BITS_AB-1:0] a_unused;
    logic [COLS-1:0][BITS_AB-1:0] b_unused;

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        assign a_h[gi][0]   = a_edge[gi];
        assign a_unused[gi] = a_h[gi][COLS];
        for (genvar gj = 0; gj < COLS; gj++) begin : g_col
            sa_pe #(
                .BITS_AB(BITS_AB),
                .BITS_C (BITS_C),
                .SAT    (SAT)
            ) u_pe (
                .clk  (clk),
                .rst  (rst),
                .adv  (adv),
                .clr  (clr),
                .a_in (a_h[gi][gj]),
                .b_in (b_v[gi][gj]),
                .a_out(a_h[gi][gj+1]),
                .b_out(b_v[gi+1][gj]),
                .acc  (acc_row[gi][gj])
            );
        end
    end

    for (genvar gj = 0; gj < COLS; gj++) begin : g_bedge
        assign b_v[0][gj]   = b_edge[gj];
        assign b_unused[gj] = b_v[ROWS][gj];
    end

    assign Cout = acc_row[out_row];

endmodule

// File: tb/tb_systolic_array_stream.sv
// Directed bench for systolic_array_stream: identity, stalls, accumulate,
// saturation vs. wrap, output backpressure and mid-tile reset.
module tb_systolic_array_stream;

    localparam int R  = 8;
    localparam int C  = 8;
    localparam int W  = 8;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst, start, acc_clr, in_valid, in_last, out_ready;
    logic [R-1:0][W-1:0]  A;
    logic [C-1:0][W-1:0]  B;

    logic in_ready, out_valid, busy, done;
    logic [2:0] out_row;
    logic [C-1:0][CW-1:0] Cout;

    logic in_ready_w, out_valid_w, busy_w, done_w;
    logic [2:0] out_row_w;
    logic [C-1:0][CW-1:0] Cout_w;

    always #5 clk = ~clk;

    systolic_array_stream #(
        .BITS_AB(W), .BITS_C(CW), .ROWS(R), .COLS(C), .SAT(1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .acc_clr(acc_clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .Cout(Cout), .busy(busy), .done(done)
    );

    systolic_array_stream #(
        .BITS_AB(W), .BITS_C(CW), .ROWS(R), .COLS(C), .SAT(0)
    ) dut_w (
        .clk(clk), .rst(rst), .start(start), .acc_clr(acc_clr),
        .in_valid(in_valid), .in_ready(in_ready_w), .in_last(in_last),
        .A(A), .B(B), .out_valid(out_valid_w), .out_ready(out_ready),
        .out_row(out_row_w), .Cout(Cout_w), .busy(busy_w), .done(done_w)
    );

    int n_vec = 0;
    int n_bad = 0;

    int ta  [8][R];
    int tbv [8][C];
    int ms  [R][C];
    int mw  [R][C];

    task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int sat16(int s);
        if (s > 32767)  return 32767;
        if (s < -32768) return -32768;
        return s;
    endfunction

    function automatic int wrap16(int s);
        shortint t;
        t = shortint'(s);
        return int'(t);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) begin
                ms[i][j] = 0;
                mw[i][j] = 0;
            end
    endtask

    task automatic model_beat(int k);
        int p;
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) begin
                p = ta[k][i] * tbv[k][j];
                ms[i][j] = sat16(ms[i][j] + p);
                mw[i][j] = wrap16(mw[i][j] + p);
            end
    endtask

    task automatic fill(int a_val_lo, int a_val_hi, int b_val, bit ident);
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < R; i++)
                ta[k][i] = ident ? ((i == k) ? 1 : 0)
                                 : ((i < 4) ? a_val_lo : a_val_hi);
            for (int j = 0; j < C; j++)
                tbv[k][j] = ident ? (k * 8 + j) : b_val;
        end
    endtask

    task automatic drive_beat(int k, bit v, bit last);
        in_valid = v;
        in_last  = last;
        for (int i = 0; i < R; i++) A[i] = 8'(ta[k][i]);
        for (int j = 0; j < C; j++) B[j] = 8'(tbv[k][j]);
    endtask

    task automatic run_tile(int K, bit clr, bit stall, bit junk);
        int  k;
        int  cyc;
        bit  v;
        @(negedge clk);
        start   = 1'b1;
        acc_clr = clr;
        if (junk) begin
            in_valid = 1'b1;
            in_last  = 1'b1;
            A = {R{8'h55}};
            B = {C{8'h55}};
        end
        if (clr) model_clear();
        @(negedge clk);
        start    = 1'b0;
        acc_clr  = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        cyc = 1;
        chk("in_ready_feed", 128'(in_ready), 128'(1));
        k = 0;
        while (k < K && cyc < 200) begin
            v = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            drive_beat(k, v, k == K - 1);
            @(negedge clk);
            cyc++;
            if (v) begin
                model_beat(k);
                k++;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        A = '0;
        B = '0;
        chk("in_ready_flush", 128'(in_ready), 128'(0));
        while (!out_valid && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        if (!stall) chk("latency", 128'(cyc), 128'(K + R + C));
        else        chk("drain_reached", 128'(out_valid), 128'(1));
    endtask

    task automatic drain(int bp_row, int bp_len);
        logic [C-1:0][CW-1:0] es, ew;
        out_ready = 1'b1;
        for (int r = 0; r < R; r++) begin
            for (int j = 0; j < C; j++) begin
                es[j] = 16'(ms[r][j]);
                ew[j] = 16'(mw[r][j]);
            end
            chk("out_valid", 128'(out_valid), 128'(1));
            chk("out_row", 128'(out_row), 128'(r));
            chk("cout_sat", 128'(Cout), 128'(es));
            chk("cout_wrap", 128'(Cout_w), 128'(ew));
            chk("done_early", 128'(done), 128'(0));
            if (r == bp_row) begin
                out_ready = 1'b0;
                for (int t = 0; t < bp_len; t++) begin
                    start   = 1'b1;
                    acc_clr = 1'b1;
                    @(negedge clk);
                    chk("hold_row", 128'(out_row), 128'(r));
                    chk("hold_cout", 128'(Cout), 128'(es));
                end
                start     = 1'b0;
                acc_clr   = 1'b0;
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
        chk("done_pulse", 128'(done), 128'(1));
        chk("busy_end", 128'(busy), 128'(0));
        chk("out_valid_end", 128'(out_valid), 128'(0));
        @(negedge clk);
        chk("done_once", 128'(done), 128'(0));
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        acc_clr   = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        A = '0;
        B = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_out_row", 128'(out_row), 128'(0));
        chk("rst_cout", 128'(Cout), 128'(0));
        rst = 1'b0;

        fill(0, 0, 0, 1'b1);
        run_tile(8, 1'b1, 1'b0, 1'b0);
        drain(-1, 0);

        run_tile(8, 1'b1, 1'b1, 1'b0);
        drain(3, 10);

        fill(1, 1, 1, 1'b0);
        run_tile(4, 1'b1, 1'b0, 1'b0);
        drain(-1, 0);
        fill(2, 2, 2, 1'b0);
        run_tile(2, 1'b0, 1'b0, 1'b1);
        drain(-1, 0);

        fill(127, -128, 127, 1'b0);
        run_tile(3, 1'b1, 1'b0, 1'b0);
        drain(-1, 0);

        fill(0, 0, 0, 1'b1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_beat(k, 1'b1, 1'b0);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        chk("mid_in_ready", 128'(in_ready), 128'(0));
        chk("mid_busy", 128'(busy), 128'(0));
        chk("mid_out_valid", 128'(out_valid), 128'(0));
        chk("mid_out_row", 128'(out_row), 128'(0));
        chk("mid_cout", 128'(Cout), 128'(0));
        chk("mid_done", 128'(done), 128'(0));
        in_valid = 1'b0;
        A = '0;
        B = '0;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        run_tile(8, 1'b0, 1'b0, 1'b0);
        drain(-1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
